// File: rtl/lut_layer_pkg.sv
// Shared types for the runtime-loadable LUT neuron layer.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } lut_state_e;

  // Index width with a floor of one bit so a single-neuron layer still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: sync write, async read, contents survive reset.
module lut_neuron_ram #(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [FAN_IN-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [FAN_IN-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [2**FAN_IN];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_layer_rt.sv
// LogicNets LUT layer with runtime-written tables and a 2-stage valid/ready pipeline.
module lut_layer_rt
  import lut_layer_pkg::*;
#(
  parameter  int N_NEURONS = 8,
  parameter  int FAN_IN    = 6,
  parameter  int OUT_BITS  = 1,
  localparam int NW        = idx_w(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [FAN_IN-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  input  logic                          cfg_commit,
  output logic                          cfg_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*FAN_IN-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  output logic [1:0]                    state_o
);

  localparam int STAGES = 2;

  lut_state_e                         state;
  logic [STAGES:1]                    vld_pipe;
  logic                               en, xfer, in_range, wr_ok;
  logic [N_NEURONS-1:0][FAN_IN-1:0]   s1_addr;
  logic [N_NEURONS-1:0][OUT_BITS-1:0] rd_data;
  logic [N_NEURONS-1:0]               wr_en;

  assign en        = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = (state == RUN) & en;
  assign xfer      = in_valid & in_ready;
  assign out_valid = vld_pipe[STAGES];
  assign state_o   = state;

  // A power-of-two layer fills the index space, so every index is in range.
  if (N_NEURONS == (1 << NW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (cfg_neuron < NW'(N_NEURONS));
  end

  assign wr_ok = cfg_we & in_range & ((state == IDLE) | (state == LOAD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & !wr_ok;
      case (state)
        IDLE:    if (cfg_commit) state <= RUN;
                 else if (wr_ok) state <= LOAD;
        LOAD:    if (cfg_commit) state <= RUN;
        RUN:     if (cfg_commit) state <= DRAIN;
        DRAIN:   if (!vld_pipe[1] && !vld_pipe[2]) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      out_data <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
      out_data <= rd_data;
    end
  end

  // Address register carries no reset: its contents only matter under vld_pipe[1].
  always_ff @(posedge clk)
    if (en) s1_addr <= in_data;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
    assign wr_en[i] = wr_ok & (cfg_neuron == NW'(i));

    lut_neuron_ram #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en[i]),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (s1_addr[i]),
      .rdata (rd_data[i])
    );
  end

endmodule
